// File: rtl/tpu_sequencer.sv
// Command sequencer for the TPU datapath: drives UB reads, weight loads, SA steps and ACC writes.
// Latency: first strobe one cycle after accept; done follows the last strobe (NOP/rows=0: two cycles).
// Backpressure: one command at a time; cmd_ready is low from accept through the done pulse.
module tpu_sequencer #(
   parameter int ARRAY_SIZE = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_rows,
   output logic                  ub_rd_en,
   output logic [ADDR_WIDTH-1:0] ub_rd_addr,
   output logic                  wt_load,
   output logic                  sa_en,
   output logic                  acc_wr_en,
   output logic [ADDR_WIDTH-1:0] acc_wr_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CNT_W = $clog2(2 * ARRAY_SIZE) + 1;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_MATMUL = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]      drn_cnt_q, drn_cnt_d;
   logic [CNT_W-1:0]      wr_dly_q, wr_dly_d;
   logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
   logic                  ub_rd_en_q, ub_rd_en_d;
   logic [ADDR_WIDTH-1:0] ub_rd_addr_q, ub_rd_addr_d;
   logic                  wt_load_q, wt_load_d;
   logic                  sa_en_q, sa_en_d;
   logic                  acc_wr_en_q, acc_wr_en_d;
   logic [ADDR_WIDTH-1:0] acc_wr_addr_q, acc_wr_addr_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  accept;

   // The done pulse trails the DONE state by one cycle, so keep the port closed through it.
   assign cmd_ready = (state_q == S_IDLE) && !done_q;
   assign busy      = (state_q != S_IDLE) || done_q;
   assign accept    = cmd_valid && cmd_ready;

   assign ub_rd_en    = ub_rd_en_q;
   assign ub_rd_addr  = ub_rd_addr_q;
   assign wt_load     = wt_load_q;
   assign sa_en       = sa_en_q;
   assign acc_wr_en   = acc_wr_en_q;
   assign acc_wr_addr = acc_wr_addr_q;
   assign done        = done_q;
   assign err         = err_q;

   // Command FSM: latches fields, issues UB reads and SA steps one cycle ahead of the outputs.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      dst_d        = dst_q;
      rd_cnt_d     = rd_cnt_q;
      drn_cnt_d    = drn_cnt_q;
      ub_rd_en_d   = 1'b0;
      ub_rd_addr_d = ub_rd_addr_q;
      sa_en_d      = 1'b0;
      err_d        = err_q;
      // Weight rows arrive one cycle after their UB read.
      wt_load_d    = ub_rd_en_q && (op_q == OP_LOAD);
      done_d       = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = cmd_op;
               dst_d = cmd_dst_addr;
               case (cmd_op)
                  OP_LOAD: begin
                     state_d      = S_LOAD_W;
                     ub_rd_en_d   = 1'b1;
                     ub_rd_addr_d = cmd_src_addr;
                     rd_cnt_d     = LEN_WIDTH'(ARRAY_SIZE - 1);
                  end
                  OP_MATMUL: begin
                     if (cmd_rows != '0) begin
                        state_d      = S_FEED;
                        ub_rd_en_d   = 1'b1;
                        ub_rd_addr_d = cmd_src_addr;
                        sa_en_d      = 1'b1;
                        rd_cnt_d     = cmd_rows - LEN_WIDTH'(1);
                     end else begin
                        state_d = S_DONE;
                     end
                  end
                  OP_RSVD: begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end
         S_LOAD_W: begin
            if (rd_cnt_q != '0) begin
               ub_rd_en_d   = 1'b1;
               ub_rd_addr_d = ub_rd_addr_q + ADDR_WIDTH'(1);
               rd_cnt_d     = rd_cnt_q - LEN_WIDTH'(1);
            end else begin
               state_d = S_DONE;
            end
         end
         S_FEED: begin
            sa_en_d = 1'b1;
            if (rd_cnt_q != '0) begin
               ub_rd_en_d   = 1'b1;
               ub_rd_addr_d = ub_rd_addr_q + ADDR_WIDTH'(1);
               rd_cnt_d     = rd_cnt_q - LEN_WIDTH'(1);
            end else begin
               state_d   = S_DRAIN;
               drn_cnt_d = CNT_W'(2 * ARRAY_SIZE - 1);
            end
         end
         S_DRAIN: begin
            // The final SA step is issued while entering DONE.
            sa_en_d   = 1'b1;
            drn_cnt_d = drn_cnt_q - CNT_W'(1);
            if (drn_cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ACC write window: 2N-cycle delay then R consecutive writes, independent of FEED/DRAIN.
   always_comb begin
      wr_dly_d      = wr_dly_q;
      wr_cnt_d      = wr_cnt_q;
      acc_wr_en_d   = 1'b0;
      acc_wr_addr_d = acc_wr_addr_q;
      if (accept && (cmd_op == OP_MATMUL) && (cmd_rows != '0)) begin
         wr_dly_d = CNT_W'(2 * ARRAY_SIZE);
         wr_cnt_d = cmd_rows;
      end else if (wr_dly_q != '0) begin
         wr_dly_d = wr_dly_q - CNT_W'(1);
         if (wr_dly_q == CNT_W'(1)) begin
            acc_wr_en_d   = 1'b1;
            acc_wr_addr_d = dst_q;
            wr_cnt_d      = wr_cnt_q - LEN_WIDTH'(1);
         end
      end else if (wr_cnt_q != '0) begin
         acc_wr_en_d   = 1'b1;
         acc_wr_addr_d = acc_wr_addr_q + ADDR_WIDTH'(1);
         wr_cnt_d      = wr_cnt_q - LEN_WIDTH'(1);
      end
   end

   // State, counters and registered outputs; reset aborts any command in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         op_q          <= OP_NOP;
         dst_q         <= '0;
         rd_cnt_q      <= '0;
         drn_cnt_q     <= '0;
         wr_dly_q      <= '0;
         wr_cnt_q      <= '0;
         ub_rd_en_q    <= 1'b0;
         ub_rd_addr_q  <= '0;
         wt_load_q     <= 1'b0;
         sa_en_q       <= 1'b0;
         acc_wr_en_q   <= 1'b0;
         acc_wr_addr_q <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         dst_q         <= dst_d;
         rd_cnt_q      <= rd_cnt_d;
         drn_cnt_q     <= drn_cnt_d;
         wr_dly_q      <= wr_dly_d;
         wr_cnt_q      <= wr_cnt_d;
         ub_rd_en_q    <= ub_rd_en_d;
         ub_rd_addr_q  <= ub_rd_addr_d;
         wt_load_q     <= wt_load_d;
         sa_en_q       <= sa_en_d;
         acc_wr_en_q   <= acc_wr_en_d;
         acc_wr_addr_q <= acc_wr_addr_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Command-driven controller that sequences the TPU datapath: the unified buffer (UB), the N×N systolic array (SA) and the accumulator bank (ACC).
- Accepts one command at a time over a valid/ready handshake.
- Generates UB read addresses, weight-load strobes, SA advance enables and ACC write addresses.
- Sits between the TPU instruction fetch/decode and the datapath inside the `tpu` top level.

Parameters:
- ARRAY_SIZE, 4, systolic array dimension N (N ≥ 2).
- ADDR_WIDTH, 8, UB/ACC address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- LEN_WIDTH, 8, width of the row-count field.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 NOP, 01 LOAD_WEIGHTS, 10 MATMUL, 11 reserved.
- cmd_src_addr  in  ADDR_WIDTH  UB start address.
- cmd_dst_addr  in  ADDR_WIDTH  ACC start address (MATMUL only).
- cmd_rows  in  LEN_WIDTH  input row count (MATMUL only).
- ub_rd_en  out  1  UB read strobe; read data is valid one cycle later.
- ub_rd_addr  out  ADDR_WIDTH  UB read address.
- wt_load  out  1  shift the current UB data row into the SA weight registers.
- sa_en  out  1  advance the systolic array one step.
- acc_wr_en  out  1  ACC write strobe.
- acc_wr_addr  out  ADDR_WIDTH  ACC write address.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky; set by a reserved opcode.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state → IDLE; all counters cleared.
  - cmd_ready = 1; all other outputs = 0, including err.
  - Asserting reset mid-command aborts the command immediately; no done pulse is produced.
- Handshake:
  - cmd_ready = 1 only in IDLE.
  - A command is accepted on a rising edge with cmd_valid & cmd_ready; call that edge cycle c.
  - All command fields are latched at c; later changes on the cmd_* inputs are ignored.
- States: IDLE, LOAD_W, FEED, DRAIN, DONE.
- IDLE → on accept:
  - op 00 → DONE.
  - op 11 → set err, → DONE.
  - op 01 → LOAD_W.
  - op 10 → FEED if cmd_rows ≠ 0, else → DONE.
- LOAD_W:
  - Cycles c+1 .. c+N: ub_rd_en = 1, ub_rd_addr = src + i for i = 0..N-1.
  - Cycles c+2 .. c+N+1: wt_load = 1, covering the UB latency.
  - Then DONE at cycle c+N+2.
  - sa_en and acc_wr_en stay 0.
- MATMUL, with t0 = c+1 and R = cmd_rows:
  - FEED, cycles t0 .. t0+R-1: ub_rd_en = 1, ub_rd_addr = src + i.
  - DRAIN, cycles t0+R .. t0+R+2N-1: no UB reads.
  - sa_en = 1 on every FEED and DRAIN cycle.
  - acc_wr_en = 1 on cycles t0+2N .. t0+2N+R-1, with acc_wr_addr = dst + k for k = 0..R-1.
  - The write window uses its own delay and row counters and may overlap FEED when R > 2N.
  - DONE at cycle t0+R+2N.
- DONE:
  - done = 1 for exactly one cycle; busy = 1; cmd_ready = 0.
  - Next state IDLE; the earliest next accept is the cycle after done.
- Address wrap: src + i and dst + k wrap silently, e.g. 0xFE → 0xFF → 0x00 when ADDR_WIDTH = 8.
- err:
  - Stays 1 until reset.
  - Later valid commands still execute normally.
- Output registration:
  - All strobes and addresses are registered, with no combinational path from cmd_* to any output.
  - cmd_ready may be decoded from state.
- When not asserted, the address outputs hold their last value; the bench must check them only while the corresponding strobe is high.

Test Plan:
- Reset then LOAD_WEIGHTS, src = 0x10, N = 4, accepted at cycle c → ub_rd_en on c+1..c+4 with addresses 0x10..0x13; wt_load on c+2..c+5; done pulse at c+6; sa_en and acc_wr_en never high.
- MATMUL, src = 0x20, dst = 0x40, rows = 3, N = 4, accepted at c → reads 0x20..0x22 on c+1..c+3; sa_en on c+1..c+11; acc writes 0x40..0x42 on c+9..c+11; done at c+12.
- MATMUL with rows = 10 (> 2N) → reads on c+1..c+10 overlap writes starting c+9; 10 writes to dst..dst+9 in total; done at c+19.
- Edge cases:
  - MATMUL rows = 0 → done at c+2; no strobes.
  - op 11 → done at c+2 and err = 1; a following NOP completes with err still 1.
  - src = 0xFE with LOAD_WEIGHTS → addresses 0xFE, 0xFF, 0x00, 0x01.
- Hold cmd_valid = 1 continuously with back-to-back commands → cmd_ready = 0 throughout busy; the second command is accepted the cycle after done; the first command's fields are unaffected by input changes.
- Drive reset low at cycle c+5 of the rows = 3 MATMUL → all outputs 0 immediately; cmd_ready = 1; no done pulse; after release, a new LOAD_WEIGHTS runs with correct timing.
